remote_access_arb: RTL and testbench

Round-robin arbiter that lets NUM_REQ independent requesters share the single remote-access command/response port of the register/memory access block. Candidate requesters are the UART command decoder and local test/script engines. The arbiter accepts one word transaction at a time and issues it downstream as a one-cycle command pulse. It then waits for the downstream response pulse and routes the response back to the granted requester. A response timeout guarantees forward progress if the downstream side never answers, e.g. an unmapped address.

---
 rtl/remote_access_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/remote_access_arb.sv | 171 +++++++++++++++++
 tb/tb_remote_access_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remote_access_pkg.sv
// Shared types and constants for the remote-access round-robin arbiter.
package remote_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rarb_state_t;

    localparam logic [31:0] RARB_TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int          RA_ADDR_W         = 16;
    localparam int          RA_DATA_W         = 32;
    localparam int          RA_CNT_W          = 8;

    // Distance of requester j from the round-robin start point (last + 1); 0 is highest priority.
    function automatic int rr_distance(input int j, input int last, input int n);
        return (j - last - 1 + 2 * n) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the lowest distance from last_grant+1 (with wrap) wins.
module rr_arbiter
    import remote_access_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    int w_best;

    always_comb begin
        w_best      = NUM_REQ;
        o_grant_idx = '0;
        o_grant     = '0;
        o_any       = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (i_req[j] && (rr_distance(j, int'(i_last_grant), NUM_REQ) < w_best)) begin
                w_best      = rr_distance(j, int'(i_last_grant), NUM_REQ);
                o_grant_idx = IDX_W'(j);
            end
        end
        if (w_best < NUM_REQ) begin
            o_any   = 1'b1;
            o_grant = NUM_REQ'(1) << o_grant_idx;
        end
    end

endmodule

// File: rtl/remote_access_arb.sv
// Shares the single remote-access command/response port among NUM_REQ requesters,
// one word transaction at a time, with a response timeout for forward progress.
module remote_access_arb
    import remote_access_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_wr,
    input  logic [NUM_REQ-1:0][RA_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][RA_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [RA_DATA_W-1:0]              rsp_data,
    output logic                              rsp_err,
    output logic                              cmd_valid,
    output logic                              cmd_wr_word,
    output logic                              cmd_rd_word,
    output logic [RA_ADDR_W-1:0]              cmd_addr,
    output logic [RA_DATA_W-1:0]              cmd_data,
    input  logic                              dn_rsp_valid,
    input  logic [RA_DATA_W-1:0]              dn_rsp_data
);

    localparam int                  IDX_W          = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]    LAST_GRANT_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [RA_CNT_W-1:0] TIMEOUT_LAST   = RA_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RA_CNT_W-1:0] CNT_ONE        = RA_CNT_W'(1);

    rarb_state_t          r_state;
    logic [IDX_W-1:0]     r_last_grant;
    logic [RA_ADDR_W-1:0] r_cmd_addr;
    logic [RA_DATA_W-1:0] r_cmd_data;
    logic [RA_CNT_W-1:0]  r_count;
    logic [RA_DATA_W-1:0] r_rsp_data;
    logic                 r_rsp_err;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_cmd_valid;
    logic                 r_cmd_wr;
    logic                 r_cmd_rd;

    rarb_state_t          w_state_nxt;
    logic [IDX_W-1:0]     w_last_grant_nxt;
    logic [RA_ADDR_W-1:0] w_addr_nxt;
    logic [RA_DATA_W-1:0] w_data_nxt;
    logic [RA_CNT_W-1:0]  w_count_nxt;
    logic [RA_DATA_W-1:0] w_rsp_data_nxt;
    logic                 w_rsp_err_nxt;
    logic [NUM_REQ-1:0]   w_rsp_valid_nxt;
    logic                 w_cmd_valid_nxt;
    logic                 w_cmd_wr_nxt;
    logic                 w_cmd_rd_nxt;
    logic [NUM_REQ-1:0]   w_ready;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_owner_1hot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    // last_grant doubles as the owner of the transaction in flight.
    assign w_owner_1hot = NUM_REQ'(1) << r_last_grant;

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_addr_nxt       = r_cmd_addr;
        w_data_nxt       = r_cmd_data;
        w_count_nxt      = r_count;
        w_rsp_data_nxt   = r_rsp_data;
        w_rsp_err_nxt    = 1'b0;
        w_rsp_valid_nxt  = '0;
        w_cmd_valid_nxt  = 1'b0;
        w_cmd_wr_nxt     = 1'b0;
        w_cmd_rd_nxt     = 1'b0;
        w_ready          = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_ready          = w_grant;
                    w_last_grant_nxt = w_grant_idx;
                    w_addr_nxt       = req_addr[w_grant_idx];
                    w_data_nxt       = req_data[w_grant_idx];
                    w_cmd_valid_nxt  = 1'b1;
                    w_cmd_wr_nxt     = req_wr[w_grant_idx];
                    w_cmd_rd_nxt     = !req_wr[w_grant_idx];
                    w_state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                w_count_nxt = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A real answer on the timeout cycle beats the timeout.
                if (dn_rsp_valid) begin
                    w_rsp_data_nxt  = dn_rsp_data;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_valid_nxt = w_owner_1hot;
                    w_state_nxt     = RESP;
                end else if (r_count == TIMEOUT_LAST) begin
                    w_rsp_data_nxt  = RARB_TIMEOUT_DATA;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = w_owner_1hot;
                    w_state_nxt     = RESP;
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= IDLE;
            r_last_grant <= LAST_GRANT_RST;
            r_cmd_addr   <= '0;
            r_cmd_data   <= '0;
            r_count      <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_wr     <= 1'b0;
            r_cmd_rd     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cmd_addr   <= w_addr_nxt;
            r_cmd_data   <= w_data_nxt;
            r_count      <= w_count_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_cmd_valid  <= w_cmd_valid_nxt;
            r_cmd_wr     <= w_cmd_wr_nxt;
            r_cmd_rd     <= w_cmd_rd_nxt;
        end
    end

    // The acceptance pulse is combinational, so it is gated to stay low while reset is held.
    assign req_ready   = w_ready & {NUM_REQ{RSTN}};
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_wr_word = r_cmd_wr;
    assign cmd_rd_word = r_cmd_rd;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_data    = r_cmd_data;

endmodule

// File: tb/tb_remote_access_arb.sv
// Self-checking bench for remote_access_arb: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-timeline reference model.
module tb_remote_access_arb;

    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 15;

    logic                    CLK = 1'b0;
    logic                    RSTN;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_wr;
    logic [NUM_REQ-1:0][15:0] req_addr;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [31:0]             rsp_data;
    logic                    rsp_err;
    logic                    cmd_valid;
    logic                    cmd_wr_word;
    logic                    cmd_rd_word;
    logic [15:0]             cmd_addr;
    logic [31:0]             cmd_data;
    logic                    dn_rsp_valid;
    logic [31:0]             dn_rsp_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    remote_access_arb #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .cmd_valid    (cmd_valid),
        .cmd_wr_word  (cmd_wr_word),
        .cmd_rd_word  (cmd_rd_word),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_data  (dn_rsp_data)
    );

    typedef struct {
        int          reqIdx;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          dnDelay;
        logic [31:0] dnData;
        logic [1:0]  expRsp;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
    } txnVec_t;

    txnVec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then wait for the sampling point.
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] wr,
                                 input logic dnValid, input logic [31:0] dnData);
        @(posedge CLK);
        #1;
        req_valid    = valid;
        req_wr       = wr;
        dn_rsp_valid = dnValid;
        dn_rsp_data  = dnData;
        @(negedge CLK);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 32'h0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'h0);
        checkOutput({tag, "_cmd_wr"}, 32'(cmd_wr_word), 32'h0);
        checkOutput({tag, "_cmd_rd"}, 32'(cmd_rd_word), 32'h0);
        checkOutput({tag, "_cmd_addr"}, 32'(cmd_addr), 32'h0);
        checkOutput({tag, "_cmd_data"}, cmd_data, 32'h0);
    endtask

    task automatic runVector(input int n, input txnVec_t v);
        logic [1:0] sel;
        int         gotAt;
        sel = 2'b01 << v.reqIdx;
        req_addr[v.reqIdx] = v.addr;
        req_data[v.reqIdx] = v.wdata;
        applyStimulus(sel, v.wr ? sel : 2'b00, 1'b0, 32'h0);
        checkOutput($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(sel));
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        checkOutput($sformatf("vec%0d_cmd_valid", n), 32'(cmd_valid), 32'h1);
        checkOutput($sformatf("vec%0d_cmd_wr", n), 32'(cmd_wr_word), 32'(v.wr));
        checkOutput($sformatf("vec%0d_cmd_rd", n), 32'(cmd_rd_word), 32'(!v.wr));
        checkOutput($sformatf("vec%0d_cmd_addr", n), 32'(cmd_addr), 32'(v.addr));
        checkOutput($sformatf("vec%0d_cmd_data", n), cmd_data, v.wdata);
        gotAt = -1;
        for (int k = 2; k <= 40 && gotAt < 0; k++) begin
            applyStimulus(2'b00, 2'b00, (v.dnDelay > 0) && (k == v.dnDelay + 1), v.dnData);
            if (rsp_valid != 2'b00) begin
                gotAt = k;
                checkOutput($sformatf("vec%0d_rsp_valid", n), 32'(rsp_valid), 32'(v.expRsp));
                checkOutput($sformatf("vec%0d_rsp_data", n), rsp_data, v.expData);
                checkOutput($sformatf("vec%0d_rsp_err", n), 32'(rsp_err), 32'(v.expErr));
            end
        end
        checkOutput($sformatf("vec%0d_latency", n), 32'(gotAt), 32'(v.expLat));
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        checkOutput($sformatf("vec%0d_rsp_drop", n), 32'(rsp_valid), 32'h0);
    endtask

    function automatic int pickWinner(input int last, input logic [1:0] valid);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (valid[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Reference model: each grant opens a transaction whose command appears one cycle later;
    // the first downstream pulse in the TIMEOUT_CYCLES-long wait window (or the window's end)
    // fixes the response one cycle later, and the arbiter is free again the cycle after that.
    task automatic runRandom(input int numCycles);
        logic [1:0]  pending;
        logic [1:0]  pendWr;
        logic [15:0] pAddr [2];
        logic [31:0] pData [2];
        logic [31:0] dnSched [int];
        bit          mBusy;
        int          mLast, mOwner, mGrantAt, mRspAt;
        logic        mWr, mErr;
        logic [15:0] mAddr;
        logic [31:0] mWdata, mRspData;
        logic [1:0]  expReady, prevReady, expRsp;
        bit          expCmd;
        pending   = '0;
        pendWr    = '0;
        prevReady = '0;
        mBusy     = 1'b0;
        mLast     = NUM_REQ - 1;
        mOwner    = 0;
        mGrantAt  = -10;
        mRspAt    = -1;
        mWr       = 1'b0;
        mErr      = 1'b0;
        mAddr     = '0;
        mWdata    = '0;
        mRspData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pAddr[i] = '0;
            pData[i] = '0;
        end
        for (int cyc = 0; cyc < numCycles; cyc++) begin
            @(posedge CLK);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prevReady[i]) pending[i] = 1'b0;
                if (!pending[i] && ($urandom_range(0, 2) == 0)) begin
                    pending[i] = 1'b1;
                    pendWr[i]  = 1'($urandom_range(0, 1));
                    pAddr[i]   = 16'($urandom);
                    pData[i]   = $urandom;
                end
                req_addr[i] = pAddr[i];
                req_data[i] = pData[i];
            end
            req_valid    = pending;
            req_wr       = pendWr;
            dn_rsp_valid = dnSched.exists(cyc);
            dn_rsp_data  = dn_rsp_valid ? dnSched[cyc] : $urandom;

            expReady = '0;
            expCmd   = mBusy && (cyc == mGrantAt + 1);
            expRsp   = (mBusy && (cyc == mRspAt)) ? 2'(1 << mOwner) : 2'b00;
            if (!mBusy && (pending != 2'b00)) begin
                mOwner   = pickWinner(mLast, pending);
                mLast    = mOwner;
                expReady = 2'(1 << mOwner);
                mBusy    = 1'b1;
                mGrantAt = cyc;
                mRspAt   = -1;
                mWr      = pendWr[mOwner];
                mAddr    = pAddr[mOwner];
                mWdata   = pData[mOwner];
                dnSched[cyc + 1 + $urandom_range(1, TIMEOUT_CYCLES + 3)] = $urandom;
            end else if (mBusy && (mRspAt < 0) && (cyc >= mGrantAt + 2)) begin
                if (dn_rsp_valid) begin
                    mRspAt   = cyc + 1;
                    mRspData = dn_rsp_data;
                    mErr     = 1'b0;
                end else if (cyc == mGrantAt + 1 + TIMEOUT_CYCLES) begin
                    mRspAt   = cyc + 1;
                    mRspData = 32'hDEAD_BEEF;
                    mErr     = 1'b1;
                end
            end

            @(negedge CLK);
            checkOutput("rnd_ready", 32'(req_ready), 32'(expReady));
            checkOutput("rnd_cmd_valid", 32'(cmd_valid), 32'(expCmd));
            checkOutput("rnd_cmd_wr", 32'(cmd_wr_word), 32'(expCmd && mWr));
            checkOutput("rnd_cmd_rd", 32'(cmd_rd_word), 32'(expCmd && !mWr));
            if (expCmd) begin
                checkOutput("rnd_cmd_addr", 32'(cmd_addr), 32'(mAddr));
                checkOutput("rnd_cmd_data", cmd_data, mWdata);
            end
            checkOutput("rnd_rsp_valid", 32'(rsp_valid), 32'(expRsp));
            if (expRsp != 2'b00) begin
                checkOutput("rnd_rsp_data", rsp_data, mRspData);
                checkOutput("rnd_rsp_err", 32'(rsp_err), 32'(mErr));
            end else begin
                checkOutput("rnd_rsp_err_idle", 32'(rsp_err), 32'h0);
            end
            if (mBusy && (cyc == mRspAt)) mBusy = 1'b0;
            prevReady = expReady;
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 1'b0, 16'h0003, 32'h0000_0000, 1,  32'h1234_5678, 2'b01, 32'h1234_5678, 1'b0, 3};
        vecs[1] = '{1, 1'b1, 16'hA010, 32'hCAFE_0001, 1,  32'h0000_00AC, 2'b10, 32'h0000_00AC, 1'b0, 3};
        vecs[2] = '{0, 1'b0, 16'h0777, 32'h0000_0000, 0,  32'h0000_0000, 2'b01, 32'hDEAD_BEEF, 1'b1, 17};
        vecs[3] = '{1, 1'b0, 16'h0042, 32'h0000_0000, 15, 32'h0BAD_F00D, 2'b10, 32'h0BAD_F00D, 1'b0, 17};
        vecs[4] = '{0, 1'b0, 16'h1F00, 32'h0000_0000, 14, 32'h5555_AAAA, 2'b01, 32'h5555_AAAA, 1'b0, 16};
        vecs[5] = '{1, 1'b1, 16'hFFFF, 32'h8000_0001, 5,  32'h0000_0001, 2'b10, 32'h0000_0001, 1'b0, 7};

        RSTN         = 1'b0;
        req_valid    = '0;
        req_wr       = '0;
        req_addr     = '0;
        req_data     = '0;
        dn_rsp_valid = 1'b0;
        dn_rsp_data  = '0;

        #12;
        checkAllZero("reset");
        req_valid = 2'b11;
        #1;
        checkOutput("reset_ready_gated", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;

        for (int i = 0; i < 6; i++) begin
            runVector(i, vecs[i]);
        end

        // Stray downstream pulse while idle must never produce a response.
        applyStimulus(2'b00, 2'b00, 1'b1, 32'h5A5A_5A5A);
        checkOutput("stray_pulse_cycle", 32'(rsp_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
            checkOutput($sformatf("stray_after%0d", k), 32'(rsp_valid), 32'h0);
        end

        // Contention from reset: grants alternate 0,1,0,1 every four cycles.
        RSTN        = 1'b0;
        req_addr[0] = 16'h1111;
        req_addr[1] = 16'h2222;
        req_data[0] = 32'h0000_1111;
        req_data[1] = 32'h0000_2222;
        repeat (2) @(posedge CLK);
        #1;
        RSTN      = 1'b1;
        req_valid = 2'b11;
        req_wr    = 2'b00;
        @(negedge CLK);
        checkOutput("cont_k0_ready", 32'(req_ready), 32'h1);
        for (int k = 1; k < 16; k++) begin
            applyStimulus(2'b11, 2'b00, (k % 4) == 2, 32'h7000_0000 + 32'(k));
            checkOutput($sformatf("cont_k%0d_ready", k), 32'(req_ready),
                        ((k % 4) == 0) ? 32'(1 << ((k / 4) % 2)) : 32'h0);
            checkOutput($sformatf("cont_k%0d_cmd_valid", k), 32'(cmd_valid), 32'((k % 4) == 1));
            if ((k % 4) == 1) begin
                checkOutput($sformatf("cont_k%0d_cmd_addr", k), 32'(cmd_addr),
                            (((k / 4) % 2) == 1) ? 32'h2222 : 32'h1111);
            end
            if ((k % 4) == 3) begin
                checkOutput($sformatf("cont_k%0d_rsp_valid", k), 32'(rsp_valid), 32'(1 << ((k / 4) % 2)));
                checkOutput($sformatf("cont_k%0d_rsp_data", k), rsp_data, 32'h7000_0000 + 32'(k - 1));
            end
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

        // Reset in the middle of WAIT aborts the transaction and restores the grant pointer.
        req_addr[0] = 16'h0BEE;
        req_data[0] = 32'h0000_0BEE;
        applyStimulus(2'b01, 2'b00, 1'b0, 32'h0);
        checkOutput("rst_setup_ready", 32'(req_ready), 32'h1);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        applyStimulus(2'b11, 2'b00, 1'b0, 32'h0);
        RSTN = 1'b0;
        #1;
        checkAllZero("rst_mid_wait");
        repeat (3) @(posedge CLK);
        #1;
        RSTN      = 1'b1;
        req_valid = 2'b00;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
            checkOutput($sformatf("rst_quiet%0d", k), 32'(rsp_valid), 32'h0);
        end
        applyStimulus(2'b11, 2'b00, 1'b0, 32'h0);
        checkOutput("rst_first_grant", 32'(req_ready), 32'h1);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        applyStimulus(2'b00, 2'b00, 1'b1, 32'h600D_600D);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);
        checkOutput("rst_post_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("rst_post_rsp_data", rsp_data, 32'h600D_600D);
        applyStimulus(2'b00, 2'b00, 1'b0, 32'h0);

        // Fresh reset so the model starts from the known grant pointer.
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        runRandom(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
